gate_identifier: RTL and testbench

// Inverse of the two-input gate evaluator. It watches a stream of (a, b, y) samples taken

---
 rtl/gate_identifier.sv | 166 ++++++++++++++++
 tb/tb_gate_identifier.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_identifier.sv
// Observes (a, b, y) samples from an unknown 2-input gate, assembles its truth table and
// reports which standard gate it is, or why identification failed.
module gate_identifier #(
   parameter int unsigned MAX_SAMPLES = 16,
   parameter bit          CHECK_REP   = 1'b1
) (
   input  logic       clk_in,
   input  logic       rstn_in,
   input  logic       clear_in,
   input  logic       sample_valid_in,
   output logic       sample_ready_out,
   input  logic       a_in,
   input  logic       b_in,
   input  logic       y_in,
   output logic       result_valid_out,
   input  logic       result_ack_in,
   output logic [7:0] match_out,
   output logic       unknown_out,
   output logic       conflict_out,
   output logic       timeout_out,
   output logic [3:0] table_out
);

   localparam int unsigned CW = $clog2(MAX_SAMPLES + 1);
   localparam logic [CW-1:0] MaxCount = CW'(MAX_SAMPLES);

   typedef enum logic [0:0] {StCollect, StResult} state_e;

   state_e        state_q, state_d;
   logic [3:0]    seen_q, seen_d;
   logic [3:0]    table_q, table_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    match_q, match_d;
   logic          unknown_q, unknown_d;
   logic          conflict_q, conflict_d;
   logic          timeout_q, timeout_d;

   logic          accept;
   logic [1:0]    idx;
   logic [3:0]    seen_new;
   logic [3:0]    table_new;
   logic [CW-1:0] count_new;
   logic          is_conflict;
   logic [7:0]    decoded;

   // Table bit index is {a,b}, so bit 3 is a=1,b=1.
   function automatic logic [7:0] decode_table(input logic [3:0] t);
      logic [7:0] m;
      m = 8'h00;
      case (t)
         4'b1000: m = 8'h01; // and
         4'b1110: m = 8'h02; // or
         4'b0110: m = 8'h04; // xor
         4'b0011: m = 8'h08; // not a
         4'b0101: m = 8'h10; // not b
         4'b0111: m = 8'h20; // nand
         4'b0001: m = 8'h40; // nor
         4'b1001: m = 8'h80; // xnor
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   assign sample_ready_out = (state_q == StCollect);
   assign result_valid_out = (state_q == StResult);
   assign match_out        = match_q;
   assign unknown_out      = unknown_q;
   assign conflict_out     = conflict_q;
   assign timeout_out      = timeout_q;
   assign table_out        = table_q;

   assign accept = sample_valid_in && sample_ready_out;
   assign idx    = {a_in, b_in};

   always_comb begin
      seen_new         = seen_q;
      seen_new[idx]    = 1'b1;
      table_new        = table_q;
      if (!seen_q[idx]) begin
         table_new[idx] = y_in;
      end
      count_new        = (count_q == MaxCount) ? count_q : count_q + 1'b1;
      is_conflict      = CHECK_REP && seen_q[idx] && (table_q[idx] != y_in);
      decoded          = decode_table(table_new);
   end

   always_comb begin
      state_d    = state_q;
      seen_d     = seen_q;
      table_d    = table_q;
      count_d    = count_q;
      match_d    = match_q;
      unknown_d  = unknown_q;
      conflict_d = conflict_q;
      timeout_d  = timeout_q;

      if (clear_in) begin
         state_d    = StCollect;
         seen_d     = 4'b0000;
         table_d    = 4'b0000;
         count_d    = '0;
         match_d    = 8'h00;
         unknown_d  = 1'b0;
         conflict_d = 1'b0;
         timeout_d  = 1'b0;
      end else begin
         case (state_q)
            StCollect: begin
               if (accept) begin
                  seen_d  = seen_new;
                  table_d = table_new;
                  count_d = count_new;
                  // Conflict outranks completion, which outranks timeout.
                  if (is_conflict) begin
                     state_d    = StResult;
                     conflict_d = 1'b1;
                  end else if (&seen_new) begin
                     state_d   = StResult;
                     match_d   = decoded;
                     unknown_d = (decoded == 8'h00);
                  end else if (count_new == MaxCount) begin
                     state_d   = StResult;
                     timeout_d = 1'b1;
                  end
               end
            end
            StResult: begin
               if (result_ack_in) begin
                  state_d    = StCollect;
                  seen_d     = 4'b0000;
                  table_d    = 4'b0000;
                  count_d    = '0;
                  match_d    = 8'h00;
                  unknown_d  = 1'b0;
                  conflict_d = 1'b0;
                  timeout_d  = 1'b0;
               end
            end
            default: state_d = StCollect;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q    <= StCollect;
         seen_q     <= 4'b0000;
         table_q    <= 4'b0000;
         count_q    <= '0;
         match_q    <= 8'h00;
         unknown_q  <= 1'b0;
         conflict_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         seen_q     <= seen_d;
         table_q    <= table_d;
         count_q    <= count_d;
         match_q    <= match_d;
         unknown_q  <= unknown_d;
         conflict_q <= conflict_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_gate_identifier.sv
// Scoreboard bench for gate_identifier: expected results are queued by the stimulus and
// checked by per-instance monitors when result_valid_out rises.
module tb_gate_identifier;

   typedef struct packed {
      logic [7:0] m;
      logic       u;
      logic       c;
      logic       t;
      logic [3:0] tbl;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clear = 1'b0;
   logic a = 1'b0, b = 1'b0, y = 1'b0;
   logic v1 = 1'b0, v2 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;

   logic       rdy1, rv1, unk1, conf1, to1;
   logic [7:0] m1;
   logic [3:0] t1;
   logic       rdy2, rv2, unk2, conf2, to2;
   logic [7:0] m2;
   logic [3:0] t2;

   int tests = 0;
   int fails = 0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   gate_identifier #(.MAX_SAMPLES(16), .CHECK_REP(1'b1)) dut1 (
      .clk_in(clk), .rstn_in(rstn), .clear_in(clear),
      .sample_valid_in(v1), .sample_ready_out(rdy1),
      .a_in(a), .b_in(b), .y_in(y),
      .result_valid_out(rv1), .result_ack_in(ack1),
      .match_out(m1), .unknown_out(unk1), .conflict_out(conf1),
      .timeout_out(to1), .table_out(t1)
   );

   gate_identifier #(.MAX_SAMPLES(4), .CHECK_REP(1'b0)) dut2 (
      .clk_in(clk), .rstn_in(rstn), .clear_in(clear),
      .sample_valid_in(v2), .sample_ready_out(rdy2),
      .a_in(a), .b_in(b), .y_in(y),
      .result_valid_out(rv2), .result_ack_in(ack2),
      .match_out(m2), .unknown_out(unk2), .conflict_out(conf2),
      .timeout_out(to2), .table_out(t2)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic cmp_res(input string who, input exp_t got, input exp_t exp);
      chk({who, "_match"},    32'(got.m),   32'(exp.m));
      chk({who, "_unknown"},  32'(got.u),   32'(exp.u));
      chk({who, "_conflict"}, 32'(got.c),   32'(exp.c));
      chk({who, "_timeout"},  32'(got.t),   32'(exp.t));
      chk({who, "_table"},    32'(got.tbl), 32'(exp.tbl));
   endtask

   // Monitors: compare on the first cycle of each presented result.
   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rv1 && !prev) begin
            if (q1.size() == 0) begin
               chk("dut1_unexpected_result", 32'd1, 32'd0);
            end else begin
               e = q1.pop_front();
               cmp_res("dut1", {m1, unk1, conf1, to1, t1}, e);
            end
         end
         prev = rv1;
      end
   end

   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rv2 && !prev) begin
            if (q2.size() == 0) begin
               chk("dut2_unexpected_result", 32'd1, 32'd0);
            end else begin
               e = q2.pop_front();
               cmp_res("dut2", {m2, unk2, conf2, to2, t2}, e);
            end
         end
         prev = rv2;
      end
   end

   // s = {a, b, y}
   task automatic send(input int d, input logic [2:0] s);
      {a, b, y} = s;
      if (d == 1) v1 = 1'b1; else v2 = 1'b1;
      @(posedge clk);
      #1;
      v1 = 1'b0;
      v2 = 1'b0;
   endtask

   task automatic send4(input int d, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] s3);
      send(d, s0);
      send(d, s1);
      send(d, s2);
      send(d, s3);
   endtask

   task automatic do_ack(input int d);
      if (d == 1) ack1 = 1'b1; else ack2 = 1'b1;
      @(posedge clk);
      #1;
      ack1 = 1'b0;
      ack2 = 1'b0;
      if (d == 1) begin
         chk("ack1_valid", 32'(rv1), 32'd0);
         chk("ack1_ready", 32'(rdy1), 32'd1);
         chk("ack1_table", 32'(t1), 32'd0);
      end else begin
         chk("ack2_valid", 32'(rv2), 32'd0);
         chk("ack2_ready", 32'(rdy2), 32'd1);
      end
   endtask

   task automatic chk_reset1(input string tag);
      chk({tag, "_ready"},    32'(rdy1),  32'd1);
      chk({tag, "_valid"},    32'(rv1),   32'd0);
      chk({tag, "_match"},    32'(m1),    32'd0);
      chk({tag, "_unknown"},  32'(unk1),  32'd0);
      chk({tag, "_conflict"}, 32'(conf1), 32'd0);
      chk({tag, "_timeout"},  32'(to1),   32'd0);
      chk({tag, "_table"},    32'(t1),    32'd0);
   endtask

   initial begin
      #12;
      chk_reset1("reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // and: result one cycle after the 4th sample
      q1.push_back('{m: 8'h01, u: 1'b0, c: 1'b0, t: 1'b0, tbl: 4'b1000});
      send4(1, 3'b000, 3'b010, 3'b100, 3'b111);
      chk("and_latency_valid", 32'(rv1), 32'd1);
      chk("and_ready_low", 32'(rdy1), 32'd0);
      do_ack(1);

      // ack in collect is ignored
      ack1 = 1'b1;
      @(posedge clk);
      #1;
      ack1 = 1'b0;
      chk("idle_ack_ready", 32'(rdy1), 32'd1);

      q1.push_back('{m: 8'h20, u: 1'b0, c: 1'b0, t: 1'b0, tbl: 4'b0111});
      send4(1, 3'b110, 3'b001, 3'b101, 3'b011);
      chk("nand_valid", 32'(rv1), 32'd1);
      do_ack(1);

      q1.push_back('{m: 8'h00, u: 1'b0, c: 1'b1, t: 1'b0, tbl: 4'b0001});
      send(1, 3'b001);
      send(1, 3'b010);
      send(1, 3'b000);
      chk("conflict_valid", 32'(rv1), 32'd1);
      do_ack(1);

      // clear drops the partial table and the sample presented with it
      send(1, 3'b001);
      send(1, 3'b011);
      send(1, 3'b101);
      clear = 1'b1;
      send(1, 3'b111);
      clear = 1'b0;
      chk("clear_valid", 32'(rv1), 32'd0);
      chk("clear_ready", 32'(rdy1), 32'd1);
      chk("clear_table", 32'(t1), 32'd0);
      send(1, 3'b000);
      chk("after_clear_no_result", 32'(rv1), 32'd0);
      q1.push_back('{m: 8'h04, u: 1'b0, c: 1'b0, t: 1'b0, tbl: 4'b0110});
      send(1, 3'b011);
      send(1, 3'b101);
      send(1, 3'b110);
      chk("xor_valid", 32'(rv1), 32'd1);
      do_ack(1);

      // CHECK_REP=0 ignores the repeat; the 4th accept hits MAX_SAMPLES=4
      send(2, 3'b001);
      send(2, 3'b010);
      send(2, 3'b000);
      chk("norep_no_result", 32'(rv2), 32'd0);
      chk("norep_ready", 32'(rdy2), 32'd1);
      q2.push_back('{m: 8'h00, u: 1'b0, c: 1'b0, t: 1'b1, tbl: 4'b0001});
      send(2, 3'b010);
      chk("norep_timeout_valid", 32'(rv2), 32'd1);
      do_ack(2);

      q2.push_back('{m: 8'h00, u: 1'b0, c: 1'b0, t: 1'b1, tbl: 4'b0011});
      send4(2, 3'b001, 3'b001, 3'b011, 3'b011);
      chk("timeout_valid", 32'(rv2), 32'd1);
      do_ack(2);

      q1.push_back('{m: 8'h00, u: 1'b1, c: 1'b0, t: 1'b0, tbl: 4'b1111});
      send4(1, 3'b001, 3'b011, 3'b101, 3'b111);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(rv1), 32'd1);
         chk("hold_ready", 32'(rdy1), 32'd0);
         chk("hold_unknown", 32'(unk1), 32'd1);
         chk("hold_match", 32'(m1), 32'd0);
         chk("hold_table", 32'(t1), 32'hf);
         @(posedge clk);
         #1;
      end
      #2;
      rstn = 1'b0;
      #1;
      chk_reset1("async_reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
